// File: rtl/inferno_rom_loader_if.sv
// rtl/inferno_rom_loader_if.sv - ioctl download bus in, dn ROM-load bus out
interface inferno_rom_loader_if #(
  parameter int ADDR_W = 18
);
  logic              ioctl_download;
  logic [15:0]       ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr
  );
endinterface

// File: rtl/inferno_rom_loader.sv
// rtl/inferno_rom_loader.sv - filters hps_io ROM download into williams2 dn_* writes
// and holds the core in reset until a download completes plus a settle period.
module inferno_rom_loader #(
  parameter int          ADDR_W    = 18,
  parameter logic [15:0] DN_INDEX  = 16'd0,
  parameter logic [18:0] EXP_BYTES = 19'h28000,
  parameter int          POST_HOLD = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  inferno_rom_loader_if.slave  io,
  output logic                 core_reset,
  output logic                 rom_ok,
  output logic                 rom_err,
  output logic [18:0]          byte_count
);
  localparam int            HW        = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(POST_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic          ovf;
  logic          start;
  logic          in_range;
  logic          accept;
  logic          ok_nx;

  // A matching download restarts the load from any state except LOAD itself.
  assign start    = io.ioctl_download && (io.ioctl_index == DN_INDEX) && (state != ST_LOAD);
  assign in_range = (io.ioctl_addr[24:ADDR_W] == '0);
  assign accept   = (state == ST_LOAD) && io.ioctl_wr && in_range;
  assign ok_nx    = (byte_count == EXP_BYTES) && !ovf;

  assign core_reset = (state != ST_RUN);

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (!io.ioctl_download) state_nx = ST_CHECK;
      ST_CHECK: state_nx = ST_HOLD;
      ST_HOLD:  if (hold_cnt == '0) state_nx = ST_RUN;
      default:  state_nx = state;
    endcase
    if (start) state_nx = ST_LOAD;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      io.dn_wr   <= 1'b0;
      io.dn_addr <= '0;
      io.dn_data <= '0;
      byte_count <= '0;
      rom_ok     <= 1'b0;
      rom_err    <= 1'b0;
      ovf        <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      io.dn_wr <= accept;
      if (accept) begin
        io.dn_addr <= io.ioctl_addr[ADDR_W-1:0];
        io.dn_data <= io.ioctl_dout;
        if (byte_count != 19'h7FFFF) byte_count <= byte_count + 19'd1;
      end
      if ((state == ST_LOAD) && io.ioctl_wr && !in_range) ovf <= 1'b1;

      if (state == ST_CHECK) begin
        rom_ok   <= ok_nx;
        rom_err  <= !ok_nx;
        hold_cnt <= HOLD_INIT;
      end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end

      if (start) begin
        byte_count <= '0;
        rom_ok     <= 1'b0;
        rom_err    <= 1'b0;
        ovf        <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inferno_rom_loader.sv
// tb/tb_inferno_rom_loader.sv - directed scoreboard bench for inferno_rom_loader
module tb_inferno_rom_loader;
  localparam int          ADDR_W = 18;
  localparam logic [18:0] EXP    = 19'd40;
  localparam int          PH     = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_reset, rom_ok, rom_err;
  logic [18:0] byte_count;

  int compared   = 0;
  int mismatched = 0;
  int dn_wr_cnt  = 0;
  int base;
  logic [25:0] sb[$];

  inferno_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inferno_rom_loader #(
    .ADDR_W(ADDR_W), .DN_INDEX(16'd0), .EXP_BYTES(EXP), .POST_HOLD(PH)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .io(bus.slave),
    .core_reset(core_reset), .rom_ok(rom_ok), .rom_err(rom_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every dn_wr must match the oldest queued byte; a strobe with an empty queue fails on the valid bit.
  always @(negedge clk) begin
    logic [26:0] e;
    if (bus.dn_wr === 1'b1) begin
      dn_wr_cnt++;
      e = (sb.size() > 0) ? {1'b1, sb.pop_front()} : 27'h0;
      chk("dn_word", {5'd0, 1'b1, bus.dn_addr, bus.dn_data}, {5'd0, e});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int a, input logic [7:0] s);
    return s + 8'(a * 3);
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_out);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (expect_out) sb.push_back({a[17:0], d});
    step();
    bus.ioctl_wr = 1'b0;
    repeat (3) step();
  endtask

  task automatic download(input logic [15:0] idx, input int n, input logic [7:0] seed, input bit oor);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    step();
    for (int i = 0; i < n; i++) send_byte(25'(i), pat(i, seed), idx == 16'd0);
    if (oor) send_byte(25'h40000, 8'hA5, 1'b0);
    bus.ioctl_download = 1'b0;
  endtask

  // done = steps already taken since ioctl_download was driven low
  task automatic release_check(input string tag, input int done);
    repeat (PH + 1 - done) step();
    chk({tag, "_hold_last"}, {31'd0, core_reset}, 32'd1);
    step();
    chk({tag, "_run"}, {31'd0, core_reset}, 32'd0);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 16'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) step();
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_dn_wr", {31'd0, bus.dn_wr}, 32'd0);
    chk("rst_dn_addr", {14'd0, bus.dn_addr}, 32'd0);
    chk("rst_rom_ok", {31'd0, rom_ok}, 32'd0);
    chk("rst_rom_err", {31'd0, rom_err}, 32'd0);
    chk("rst_byte_count", {13'd0, byte_count}, 32'd0);

    reset_n = 1'b1;
    repeat (1000) step();
    chk("idle_core_reset", {31'd0, core_reset}, 32'd1);
    chk("idle_flags", {30'd0, rom_ok, rom_err}, 32'd0);
    chk("idle_dn_wr_cnt", dn_wr_cnt, 32'd0);

    base = dn_wr_cnt;
    download(16'd0, int'(EXP), 8'h11, 1'b0);
    release_check("full", 0);
    chk("full_dn_wr_cnt", dn_wr_cnt - base, 32'(EXP));
    chk("full_sb_empty", sb.size(), 32'd0);
    chk("full_rom_ok", {31'd0, rom_ok}, 32'd1);
    chk("full_rom_err", {31'd0, rom_err}, 32'd0);
    chk("full_byte_count", {13'd0, byte_count}, 32'(EXP));

    // Short set whose final byte arrives on the same cycle the download drops.
    bus.ioctl_download = 1'b1;
    step();
    chk("short_entry_core_reset", {31'd0, core_reset}, 32'd1);
    chk("short_entry_flags", {30'd0, rom_ok, rom_err}, 32'd0);
    for (int i = 0; i < int'(EXP) - 2; i++) send_byte(25'(i), pat(i, 8'h33), 1'b1);
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_addr     = 25'(EXP - 2);
    bus.ioctl_dout     = 8'hC3;
    bus.ioctl_download = 1'b0;
    sb.push_back({18'(EXP - 2), 8'hC3});
    step();
    bus.ioctl_wr = 1'b0;
    release_check("short", 1);
    chk("short_byte_count", {13'd0, byte_count}, 32'(EXP - 1));
    chk("short_flags", {30'd0, rom_ok, rom_err}, 32'd1);

    base = dn_wr_cnt;
    download(16'd0, int'(EXP), 8'h5A, 1'b1);
    release_check("oor", 0);
    chk("oor_dn_wr_cnt", dn_wr_cnt - base, 32'(EXP));
    chk("oor_byte_count", {13'd0, byte_count}, 32'(EXP));
    chk("oor_flags", {30'd0, rom_ok, rom_err}, 32'd1);

    download(16'd0, int'(EXP), 8'h77, 1'b0);
    release_check("good2", 0);
    chk("good2_flags", {30'd0, rom_ok, rom_err}, 32'd2);

    base = dn_wr_cnt;
    download(16'd1, 5, 8'h99, 1'b0);
    repeat (20) step();
    chk("idx1_core_reset", {31'd0, core_reset}, 32'd0);
    chk("idx1_flags", {30'd0, rom_ok, rom_err}, 32'd2);
    chk("idx1_byte_count", {13'd0, byte_count}, 32'(EXP));
    chk("idx1_dn_wr_cnt", dn_wr_cnt - base, 32'd0);

    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 16'd0;
    step();
    chk("reentry_core_reset", {31'd0, core_reset}, 32'd1);
    chk("reentry_flags", {30'd0, rom_ok, rom_err}, 32'd0);
    chk("reentry_byte_count", {13'd0, byte_count}, 32'd0);
    for (int i = 0; i < 5; i++) send_byte(25'(i), pat(i, 8'h42), 1'b1);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd5;
    bus.ioctl_dout = 8'hE1;
    sb.push_back({18'd5, 8'hE1});
    step();
    bus.ioctl_wr = 1'b0;
    chk("pre_reset_dn_wr", {31'd0, bus.dn_wr}, 32'd1);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_dn_wr", {31'd0, bus.dn_wr}, 32'd0);
    chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("relload_core_reset", {31'd0, core_reset}, 32'd1);
    chk("relload_byte_count", {13'd0, byte_count}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(25'(i + 8), pat(i, 8'h0F), 1'b1);
    chk("relload_count3", {13'd0, byte_count}, 32'd3);
    bus.ioctl_download = 1'b0;
    release_check("relload", 0);
    chk("relload_flags", {30'd0, rom_ok, rom_err}, 32'd1);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
